// File: rtl/seqdet_pattern_src.sv
// Serial pattern source for seqdet: one-entry load buffer feeding an MSB-first shifter.
// Words run once or circulate; a pending word takes over only at a word boundary.
module seqdet_pattern_src #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_mode_i,
    input  logic             flush_i,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [WIDTH-1:0]   hold_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hold_mode_q;
    logic               hold_full_q;
    logic               mode_q;

    logic               accept_d;
    logic               last_bit_d;
    logic [WIDTH-1:0]   sr_shift_d;

    assign accept_d   = load_valid_i & ~hold_full_q;
    assign last_bit_d = (state_q == SHIFT) && (cnt_q == LAST);
    // Circulating words feed the MSB back in, so WIDTH shifts restore the word.
    assign sr_shift_d = {sr_q[WIDTH-2:0], mode_q & sr_q[WIDTH-1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_mode_q <= 1'b0;
            hold_full_q <= 1'b0;
            mode_q      <= 1'b0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            // Accept needs an empty buffer, so it never collides with a transfer out of it.
            if (accept_d) begin
                hold_q      <= load_data_i;
                hold_mode_q <= load_mode_i;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        sr_q        <= hold_q;
                        mode_q      <= hold_mode_q;
                        cnt_q       <= '0;
                        hold_full_q <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        sr_q  <= sr_shift_d;
                        cnt_q <= cnt_q + 1'b1;
                    end else if (hold_full_q) begin
                        sr_q        <= hold_q;
                        mode_q      <= hold_mode_q;
                        cnt_q       <= '0;
                        hold_full_q <= 1'b0;
                    end else if (mode_q) begin
                        sr_q  <= sr_shift_d;
                        cnt_q <= '0;
                    end else begin
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs are simple gates on flops, so seqdet sees glitch-free timing.
    assign x_o          = (state_q == SHIFT) & sr_q[WIDTH-1];
    assign x_valid_o    = (state_q == SHIFT);
    assign word_done_o  = last_bit_d;
    assign load_ready_o = ~hold_full_q;
    assign busy_o       = (state_q == SHIFT) | hold_full_q;

endmodule
